// File: rtl/led_pattern_scheduler.sv
// -----------------------------------------------------------------------------
// led_pattern_scheduler
//
// Steps the four LED driver channels through one of four flash patterns.
// A pattern is a list of start masks. Each mask is held until every channel
// in it has reported done. A one-cycle all-zero gap separates consecutive
// masks so that the drivers restart their counters. When a pattern has run
// REPEAT rounds, the scheduler moves on to the next pattern: either the
// pending request, or cur_mode+1.
//
// Optional feature macro: LED_SCHED_TIMEOUT_EN
//   Defined   : a per-step watchdog forces a stuck step to complete after
//               TIMEOUT_CYCLES clocks in RUN and pulses err for one cycle.
//   Undefined : no watchdog is built, RUN waits forever, and err is tied low.
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   en             run enable; low parks the scheduler in IDLE
//   flash_ms       flash period in ms, latched at every mode start (0 -> 1)
//   mode_req_valid pattern-change request valid
//   mode_req_id    requested mode
//   mode_req_ready request slot is empty
//   done_in        per-channel one-cycle done pulses from the drivers
//   start_out      per-channel start level to the drivers
//   set_ms_out     per-channel ms setting, channel 0 in the LSBs
//   cur_mode       mode currently running
//   mode_done      one-cycle pulse when a mode finishes REPEAT rounds
//   err            one-cycle watchdog pulse (optional feature only)
// -----------------------------------------------------------------------------
module led_pattern_scheduler #(
  parameter int unsigned REPEAT         = 4,
  parameter int unsigned MS_W           = 14,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [MS_W-1:0]   flash_ms,
  input  logic              mode_req_valid,
  input  logic [1:0]        mode_req_id,
  output logic              mode_req_ready,
  input  logic [3:0]        done_in,
  output logic [3:0]        start_out,
  output logic [4*MS_W-1:0] set_ms_out,
  output logic [1:0]        cur_mode,
  output logic              mode_done,
  output logic              err
);

  if (REPEAT < 1 || REPEAT > 15) begin : g_bad_repeat
    $error("led_pattern_scheduler: REPEAT must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 24'd2) begin : g_bad_timeout
    $error("led_pattern_scheduler: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_GAP, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [3:0]      round_q, round_d;
  logic [3:0]      seen_q, seen_d;
  logic [1:0]      mode_q, mode_d;
  logic            pend_v_q, pend_v_d;
  logic [1:0]      pend_id_q, pend_id_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [3:0]      start_q, start_d;
  logic            mode_done_q, mode_done_d;
  logic            ready_q;

  logic [3:0]      mask_cur;
  logic [3:0]      hit;
  logic            done_cplt;
  logic            timeout_hit;
  logic            step_cplt;
  logic            last_step;
  logic            last_round;
  logic [MS_W-1:0] latched_ms;

  function automatic logic [3:0] step_mask(input logic [1:0] mode, input logic [2:0] step);
    logic [3:0] m;
    m = 4'b0000;
    unique case (mode)
      2'd0: begin
        unique case (step)
          3'd0:    m = 4'b0001;
          3'd1:    m = 4'b0010;
          3'd2:    m = 4'b0100;
          default: m = 4'b1000;
        endcase
      end
      2'd1: begin
        unique case (step)
          3'd0:    m = 4'b0001;
          3'd1:    m = 4'b0011;
          3'd2:    m = 4'b0111;
          3'd3:    m = 4'b1111;
          3'd4:    m = 4'b1110;
          3'd5:    m = 4'b1100;
          default: m = 4'b1000;
        endcase
      end
      2'd2:    m = (step == 3'd0) ? 4'b0101 : 4'b1010;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] final_step(input logic [1:0] mode);
    logic [2:0] s;
    unique case (mode)
      2'd0:    s = 3'd3;
      2'd1:    s = 3'd6;
      2'd2:    s = 3'd1;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  assign mask_cur   = step_mask(mode_q, step_q);
  // The done pulse that arrives in this cycle counts toward completion right away.
  assign hit        = seen_q | (done_in & mask_cur);
  assign done_cplt  = (hit == mask_cur);
  assign step_cplt  = (state_q == S_RUN) && (done_cplt || timeout_hit);
  assign last_step  = (step_q == final_step(mode_q));
  assign last_round = (round_q == 4'(REPEAT - 1));
  assign latched_ms = (flash_ms == '0) ? MS_W'(1) : flash_ms;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_GAP;
        S_GAP:   state_d = S_RUN;
        S_RUN:   state_d = step_cplt ? S_GAP : S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and sequencing logic
  always_comb begin
    step_d      = step_q;
    round_d     = round_q;
    seen_d      = seen_q;
    mode_d      = mode_q;
    pend_v_d    = pend_v_q;
    pend_id_d   = pend_id_q;
    ms_d        = ms_q;
    mode_done_d = 1'b0;

    if (!en) begin
      step_d  = '0;
      round_d = '0;
      seen_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          step_d  = '0;
          round_d = '0;
          seen_d  = '0;
          ms_d    = latched_ms;
        end
        S_GAP: seen_d = '0;
        S_RUN: begin
          seen_d = hit;
          if (step_cplt) begin
            seen_d = '0;
            if (!last_step) begin
              step_d = step_q + 3'd1;
            end else begin
              step_d = '0;
              if (!last_round) begin
                round_d = round_q + 4'd1;
              end else begin
                round_d     = '0;
                mode_done_d = 1'b1;
                ms_d        = latched_ms;
                if (pend_v_q) begin
                  mode_d   = pend_id_q;
                  pend_v_d = 1'b0;
                end else begin
                  mode_d = mode_q + 2'd1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end

    // The slot can only be filled while it is empty, so a fill can never
    // coincide with the boundary that drains it.
    if (mode_req_valid && ready_q) begin
      pend_v_d  = 1'b1;
      pend_id_d = mode_req_id;
    end

    start_d = (state_d == S_RUN) ? step_mask(mode_d, step_d) : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q      <= '0;
      round_q     <= '0;
      seen_q      <= '0;
      mode_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_id_q   <= '0;
      ms_q        <= '0;
      start_q     <= '0;
      mode_done_q <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      step_q      <= step_d;
      round_q     <= round_d;
      seen_q      <= seen_d;
      mode_q      <= mode_d;
      pend_v_q    <= pend_v_d;
      pend_id_q   <= pend_id_d;
      ms_q        <= ms_d;
      start_q     <= start_d;
      mode_done_q <= mode_done_d;
      ready_q     <= !pend_v_d;
    end
  end

`ifdef LED_SCHED_TIMEOUT_EN
  logic [23:0] wd_cnt_q, wd_cnt_d;
  logic        err_q;

  // The watchdog counts consecutive RUN cycles. It restarts whenever RUN is
  // left, so every step gets a full TIMEOUT_CYCLES window.
  assign timeout_hit = (state_q == S_RUN) && (wd_cnt_q == TIMEOUT_CYCLES - 24'd1) && !done_cplt;

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == S_RUN && state_d == S_RUN) wd_cnt_d = wd_cnt_q + 24'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      err_q    <= timeout_hit && en;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  assign start_out      = start_q;
  assign set_ms_out     = {4{ms_q}};
  assign cur_mode       = mode_q;
  assign mode_done      = mode_done_q;
  assign mode_req_ready = ready_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
module tb_led_pattern_scheduler;
  localparam int REPEAT = 2;
  localparam int MS_W   = 14;

  logic              clk = 1'b0;
  logic              rst_n, en, mode_req_valid, mode_req_ready, mode_done, err;
  logic [1:0]        mode_req_id, cur_mode;
  logic [MS_W-1:0]   flash_ms;
  logic [3:0]        done_in, emu_done, man_done, start_out;
  logic [4*MS_W-1:0] set_ms_out;
  logic              emu_en;
  logic [MS_W-1:0]   fm_s;
  int                pause_cnt;

  int checks = 0;
  int errors = 0;

  assign done_in = emu_done | man_done;
  always #5 clk = ~clk;

  led_pattern_scheduler #(.REPEAT(REPEAT), .MS_W(MS_W), .TIMEOUT_CYCLES(24'd20)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flash_ms(flash_ms),
    .mode_req_valid(mode_req_valid), .mode_req_id(mode_req_id), .mode_req_ready(mode_req_ready),
    .done_in(done_in), .start_out(start_out), .set_ms_out(set_ms_out),
    .cur_mode(cur_mode), .mode_done(mode_done), .err(err)
  );

  // flash_ms as the DUT saw it at the most recent rising edge
  always @(posedge clk) fm_s <= flash_ms;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nsteps(input int m);
    int n[4];
    n = '{4, 7, 2, 1};
    return n[m];
  endfunction

  function automatic logic [3:0] pat(input int m, input int s);
    logic [3:0] p[7];
    case (m)
      0:       p = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0, 4'b0, 4'b0};
      1:       p = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
      2:       p = '{4'b0101, 4'b1010, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
      default: p = '{4'b1111, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0};
    endcase
    return p[s];
  endfunction

  function automatic logic [4*MS_W-1:0] rep(input int v);
    logic [MS_W-1:0] x;
    x = v[MS_W-1:0];
    return {x, x, x, x};
  endfunction

  typedef struct { logic [3:0] m; logic [4*MS_W-1:0] ms; } exp_t;
  exp_t exp_q[$];
  int   pend_q[$];
  int   m_mode;

  task automatic push_mode(input int mode, input int ms);
    exp_t e;
    for (int r = 0; r < REPEAT; r++)
      for (int s = 0; s < nsteps(mode); s++) begin
        e.m  = pat(mode, s);
        e.ms = rep(ms);
        exp_q.push_back(e);
      end
  endtask

  // ---------------- driver emulator ----------------
  initial begin : emu
    int cnt[4];
    logic [3:0] prev;
    for (int c = 0; c < 4; c++) cnt[c] = -1;
    prev = '0;
    emu_done = '0;
    forever begin
      @(negedge clk);
      if (!emu_en) begin
        emu_done = '0;
        for (int c = 0; c < 4; c++) cnt[c] = -1;
      end else begin
        if (start_out != 0 && start_out != prev)
          for (int c = 0; c < 4; c++) cnt[c] = start_out[c] ? int'($urandom_range(0, 5)) : -1;
        for (int c = 0; c < 4; c++) begin
          emu_done[c] = (cnt[c] == 0);
          if (cnt[c] >= 0) cnt[c]--;
        end
        if (start_out != 0 && $urandom_range(0, 7) == 0)
          emu_done = emu_done | (~start_out & 4'($urandom));
      end
      prev = start_out;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : mon
    logic [3:0] prev_start;
    int zrun, mon_pause, em, ms;
    bit nz_seen;
    exp_t e;
    prev_start = '0; zrun = 0; mon_pause = 0; nz_seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (start_out != 0 && prev_start == 0) begin
          if (pause_cnt != mon_pause) begin
            mon_pause = pause_cnt;
            nz_seen = 0;
          end
          if (nz_seen) chk("gap_len", zrun, 1);
          if (exp_q.size() == 0) begin
            chk("unexpected_step", start_out, 0);
          end else begin
            e = exp_q.pop_front();
            chk("step_mask", start_out, e.m);
            chk("set_ms", set_ms_out, e.ms);
          end
          nz_seen = 1;
        end
        zrun = (start_out == 0) ? zrun + 1 : 0;
        if (mode_done) begin
          chk("steps_left_at_done", exp_q.size(), 0);
          em = (pend_q.size() > 0) ? pend_q.pop_front() : (m_mode + 1) % 4;
          chk("cur_mode_at_done", cur_mode, em);
`ifndef LED_SCHED_TIMEOUT_EN
          chk("err_tied_low", err, 0);
`endif
          m_mode = em;
          ms = (fm_s == 0) ? 1 : int'(fm_s);
          push_mode(em, ms);
        end
        prev_start = start_out;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse(input logic [3:0] v);
    man_done = v;
    @(negedge clk);
    man_done = '0;
  endtask

  task automatic wait_start(input logic [3:0] v, input string nm);
    int n = 0;
    while (start_out != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(nm, start_out, v);
  endtask

  task automatic wait_done_mode(input int m, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mode_done && cur_mode == 2'(m)) && n < 3000);
    chk(nm, (mode_done && cur_mode == 2'(m)) ? 1 : 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit stable, errseen;
    rst_n = 0; en = 1; flash_ms = 14'd500; mode_req_valid = 0; mode_req_id = 0;
    man_done = 0; emu_en = 1; pause_cnt = 0; m_mode = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", start_out, 0);
    chk("rst_set_ms", set_ms_out, 0);
    chk("rst_cur_mode", cur_mode, 0);
    chk("rst_mode_done", mode_done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", mode_req_ready, 1);

    push_mode(0, 500);
    rst_n = 1;
    @(negedge clk) chk("latency_gap", start_out, 0);
    @(negedge clk) chk("latency_run", start_out, 4'b0001);

    // request 3 accepted, then request 2 held and stalled until the slot frees
    mode_req_valid = 1; mode_req_id = 2'd3;
    @(negedge clk);
    pend_q.push_back(3);
    chk("req1_ready_low", mode_req_ready, 0);
    mode_req_id = 2'd2;
    n = 0;
    while (!mode_req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("slot_freed", mode_req_ready, 1);
    chk("cur_mode_at_free", cur_mode, 3);
    @(negedge clk);
    pend_q.push_back(2);
    mode_req_valid = 0;
    chk("req2_accepted", mode_req_ready, 0);
    flash_ms = 14'($urandom_range(1, 16383));

    // mode 2, driven by hand
    wait_done_mode(2, "reach_mode2");
    emu_en = 0;
    wait_start(4'b0101, "m2_step0");
    pulse(4'b0001);
    @(negedge clk) chk("m2_single_done_holds", start_out, 4'b0101);
    pulse(4'b0100);
    @(negedge clk) chk("m2_advance_1010", start_out, 4'b1010);
    pulse(4'b1010);
    @(negedge clk) chk("m2_round2_0101", start_out, 4'b0101);
    pulse(4'b1111);
    @(negedge clk) chk("m2_simul_done_adv", start_out, 4'b1010);
    pulse(4'b1010);
    emu_en = 1;

    // mode 1, paused in step 3
    wait_done_mode(1, "reach_mode1");
    emu_en = 0;
    wait_start(4'b0001, "m1_s0"); pulse(4'b0001);
    wait_start(4'b0011, "m1_s1"); pulse(4'b0011);
    wait_start(4'b0111, "m1_s2"); pulse(4'b0111);
    wait_start(4'b1111, "m1_s3");
    en = 0; pause_cnt++;
    @(negedge clk);
    chk("pause_start_zero", start_out, 0);
    chk("pause_keeps_mode", cur_mode, 1);
    mode_req_valid = 1; mode_req_id = 2'd0;
    @(negedge clk);
    pend_q.push_back(0);
    mode_req_valid = 0;
    chk("req_while_paused", mode_req_ready, 0);
    flash_ms = 14'd0;
    exp_q.delete();
    push_mode(1, 1);
    repeat (3) @(negedge clk);
    chk("idle_holds_zero", start_out, 0);
    en = 1; emu_en = 1;
    @(negedge clk) chk("restart_gap", start_out, 0);
    @(negedge clk);
    chk("restart_step0", start_out, 4'b0001);
    chk("ms_zero_as_one", set_ms_out, rep(1));
    flash_ms = 14'($urandom_range(1, 16383));

    wait_done_mode(0, "pending_after_pause");
    flash_ms = 14'($urandom_range(0, 16383));
    wait_done_mode(1, "wrap_to_mode1");
    emu_en = 0;
    wait_start(4'b0001, "hold_step");
`ifdef LED_SCHED_TIMEOUT_EN
    errseen = 0; n = 0;
    while (!errseen && n < 30) begin
      @(negedge clk);
      if (err) errseen = 1;
      n++;
    end
    chk("timeout_err", errseen, 1);
    wait_start(4'b0011, "timeout_advance");
`else
    stable = 1; errseen = 0;
    repeat (60) begin
      @(negedge clk);
      if (start_out != 4'b0001) stable = 0;
      if (err) errseen = 1;
    end
    chk("hold_stable", stable, 1);
    chk("hold_no_err", errseen, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
